// File: rtl/eeprom_i2c_master_if.sv
// Command/response handshake plus the two-wire bus levels of the EEPROM initiator.
// The slave modport is the initiator block; the master modport is whoever issues commands.
interface eeprom_i2c_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       busy;
  logic       scl;
  logic       sda_out;
  logic       sda_in;

  modport master (
    output cmd_valid, cmd, cmd_data, sda_in,
    input  cmd_ready, rsp_valid, rsp_data, rsp_nack, busy, scl, sda_out
  );

  modport slave (
    input  cmd_valid, cmd, cmd_data, sda_in,
    output cmd_ready, rsp_valid, rsp_data, rsp_nack, busy, scl, sda_out
  );
endinterface

// File: rtl/eeprom_i2c_master.sv
// Two-wire EEPROM bus initiator: START/STOP 4 quarters, byte 36 quarters, then a 1-clk DONE pulse.
// One command at a time; cmd_valid while busy is dropped, and clk_ce low freezes the bus sequencing.
module eeprom_i2c_master #(
  parameter int unsigned QTR_TICKS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_ce,
  eeprom_i2c_master_if.slave bus
);
  localparam logic [2:0] CMD_START   = 3'd0;
  localparam logic [2:0] CMD_STOP    = 3'd1;
  localparam logic [2:0] CMD_WRITE   = 3'd2;
  localparam logic [2:0] CMD_RD_ACK  = 3'd3;
  localparam logic [2:0] CMD_RD_NACK = 3'd4;
  localparam logic [7:0] TICK_LAST   = 8'(QTR_TICKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_STOP, S_BIT, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] cmd_q;
  logic [7:0] sh_q;
  logic       ack_q;
  logic [7:0] tick_q;
  logic [1:0] qtr_q;
  logic [3:0] bit_q;
  logic       scl_q, sda_q, scl_d, sda_d;
  logic [7:0] rsp_data_q;
  logic       rsp_nack_q;
  logic       ready, accept, exec, ce_on, qtr_first, qtr_last, cmd_end, sample, bit_lvl;

  assign ready     = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept    = bus.cmd_valid && ready;
  assign exec      = (state_q == S_START) || (state_q == S_STOP) || (state_q == S_BIT);
  assign ce_on     = clk_ce && exec;
  assign qtr_first = ce_on && (tick_q == 8'd0);
  assign qtr_last  = ce_on && (tick_q == TICK_LAST);
  assign cmd_end   = qtr_last && (qtr_q == 2'd3) && ((state_q != S_BIT) || (bit_q == 4'd8));
  assign sample    = qtr_last && (qtr_q == 2'd1) && (state_q == S_BIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    scl_d   = scl_q;
    sda_d   = sda_q;
    // Ninth bit is the ACK slot: released for WRITE, driven low only for READ_ACK.
    bit_lvl = 1'b1;
    if (bit_q == 4'd8)            bit_lvl = (cmd_q != CMD_RD_ACK);
    else if (cmd_q == CMD_WRITE)  bit_lvl = sh_q[7];

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          case (bus.cmd)
            CMD_START:                          state_d = S_START;
            CMD_STOP:                           state_d = S_STOP;
            CMD_WRITE, CMD_RD_ACK, CMD_RD_NACK: state_d = S_BIT;
            default:                            state_d = S_DONE;
          endcase
        end
      end
      default: if (cmd_end) state_d = S_DONE;
    endcase

    // Bus levels change only on the first tick of each quarter.
    if (qtr_first) begin
      case (state_q)
        S_START: begin
          case (qtr_q)
            2'd0:    sda_d = 1'b1;
            2'd1:    {scl_d, sda_d} = 2'b11;
            2'd2:    {scl_d, sda_d} = 2'b10;
            default: {scl_d, sda_d} = 2'b00;
          endcase
        end
        S_STOP: begin
          case (qtr_q)
            2'd0:    {scl_d, sda_d} = 2'b00;
            2'd1:    {scl_d, sda_d} = 2'b10;
            default: {scl_d, sda_d} = 2'b11;
          endcase
        end
        default: begin
          case (qtr_q)
            2'd0:    {scl_d, sda_d} = {1'b0, bit_lvl};
            2'd3:    scl_d = 1'b0;
            default: scl_d = 1'b1;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q      <= 3'd0;
      sh_q       <= 8'd0;
      ack_q      <= 1'b0;
      tick_q     <= 8'd0;
      qtr_q      <= 2'd0;
      bit_q      <= 4'd0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      rsp_data_q <= 8'd0;
      rsp_nack_q <= 1'b0;
    end else begin
      scl_q <= scl_d;
      sda_q <= sda_d;
      if (accept) begin
        cmd_q  <= bus.cmd;
        sh_q   <= bus.cmd_data;
        tick_q <= 8'd0;
        qtr_q  <= 2'd0;
        bit_q  <= 4'd0;
      end else if (ce_on) begin
        if (qtr_last) begin
          tick_q <= 8'd0;
          qtr_q  <= qtr_q + 2'd1;
          if (qtr_q == 2'd3) bit_q <= bit_q + 4'd1;
        end else begin
          tick_q <= tick_q + 8'd1;
        end
        // One register serves both directions: write data shifts out as read data shifts in.
        if (sample) begin
          if (bit_q == 4'd8) ack_q <= bus.sda_in;
          else               sh_q  <= {sh_q[6:0], bus.sda_in};
        end
      end
      if (state_d == S_DONE) begin
        if (ready) begin
          rsp_data_q <= 8'd0;
          rsp_nack_q <= 1'b1;
        end else begin
          rsp_data_q <= ((cmd_q == CMD_RD_ACK) || (cmd_q == CMD_RD_NACK)) ? sh_q : 8'd0;
          rsp_nack_q <= (cmd_q == CMD_WRITE) && ack_q;
        end
      end
    end
  end

  assign bus.cmd_ready = ready;
  assign bus.busy      = !ready;
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_nack  = rsp_nack_q;
  assign bus.scl       = scl_q;
  assign bus.sda_out   = sda_q;
endmodule
